// File: rtl/line_mem_responder.sv
// Line-granular memory model answering cache-controller reads and writebacks
// after a fixed latency, with a one-cycle gap between transactions.
module line_mem_responder #(
  parameter int LATENCY  = 4,
  parameter int IDX_BITS = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic         mem_done,
  input  logic [15:0]  mem_address,
  input  logic [127:0] mem_wdata,
  output logic         mem_resp,
  output logic [127:0] mem_rdata,
  output logic         proto_err,
  output logic [15:0]  rd_count,
  output logic [15:0]  wr_count
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    GAP
  } state_t;

  state_t state, state_nx;

  logic [3:0]          cnt, cnt_nx;
  logic                op_wr;
  logic [IDX_BITS-1:0] idx;
  logic [127:0]        wdata_q;
  logic [127:0]        mem [2**IDX_BITS];

  logic [IDX_BITS-1:0] addr_idx;
  logic [IDX_BITS-1:0] rd_idx;
  logic                op_req, other_req;
  logic                accept, err_set, ld_rd;
  logic                unused_in;

  assign addr_idx  = mem_address[IDX_BITS+3:4];
  assign unused_in = ^{mem_done, mem_address[15:IDX_BITS+4],
                       mem_address[3:0]};

  assign op_req    = op_wr ? mem_write : mem_read;
  assign other_req = op_wr ? mem_read : mem_write;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    err_set  = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_read || mem_write) begin
          accept   = 1'b1;
          err_set  = mem_read && mem_write;
          cnt_nx   = 4'(LATENCY - 1);
          state_nx = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!op_req) begin
          err_set  = other_req;
          cnt_nx   = 4'd0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - 4'd1;
          if (cnt <= 4'd1) begin
            cnt_nx   = 4'd0;
            state_nx = RESP;
          end
        end
      end
      RESP:    state_nx = GAP;
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // With LATENCY=1 the read data is fetched on the accepting edge itself.
  assign rd_idx = accept ? addr_idx : idx;
  assign ld_rd  = (state_nx == RESP) && (accept ? !mem_write : !op_wr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      op_wr     <= 1'b0;
      idx       <= '0;
      wdata_q   <= '0;
      mem_rdata <= '0;
      proto_err <= 1'b0;
      rd_count  <= 16'd0;
      wr_count  <= 16'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (err_set)
        proto_err <= 1'b1;
      if (accept) begin
        op_wr   <= mem_write;
        idx     <= addr_idx;
        wdata_q <= mem_wdata;
      end
      if (ld_rd)
        mem_rdata <= mem[rd_idx];
      if (state == RESP) begin
        if (op_wr) begin
          if (wr_count != 16'hFFFF)
            wr_count <= wr_count + 16'd1;
        end else if (rd_count != 16'hFFFF) begin
          rd_count <= rd_count + 16'd1;
        end
      end
    end
  end

  // Array is never cleared; reset only blocks a pending commit.
  always_ff @(posedge clk) begin
    if (!reset && state == RESP && op_wr)
      mem[idx] <= wdata_q;
  end

  assign mem_resp = (state == RESP);

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder: one LATENCY=4 instance for
// protocol cases and one LATENCY=1 instance for back-to-back reads.
module tb_line_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, mem_read, mem_write, mem_done;
  logic [15:0]  mem_address;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_resp, proto_err;
  logic [15:0]  rd_count, wr_count;

  logic         l1_reset, l1_read, l1_write, l1_done;
  logic [15:0]  l1_address;
  logic [127:0] l1_wdata, l1_rdata;
  logic         l1_resp, l1_err;
  logic [15:0]  l1_rd_count, l1_wr_count;

  line_mem_responder #(.LATENCY(4), .IDX_BITS(4)) dut (
    .clk(clk), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write), .mem_done(mem_done),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata), .proto_err(proto_err),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  line_mem_responder #(.LATENCY(1), .IDX_BITS(4)) dut1 (
    .clk(clk), .reset(l1_reset),
    .mem_read(l1_read), .mem_write(l1_write), .mem_done(l1_done),
    .mem_address(l1_address), .mem_wdata(l1_wdata),
    .mem_resp(l1_resp), .mem_rdata(l1_rdata), .proto_err(l1_err),
    .rd_count(l1_rd_count), .wr_count(l1_wr_count)
  );

  localparam logic [127:0] DA = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] DB = 128'hDEADBEEFCAFEF00D1122334455667788;
  localparam logic [127:0] DC = 128'h0F0F0F0F0F0F0F0FA5A5A5A5A5A5A5A5;
  localparam logic [127:0] ONES = {128{1'b1}};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the request until mem_resp (or 20 cycles), scrambling address
  // and data after the first edge, then releases and returns to IDLE.
  task automatic txn(input logic rd, input logic wr,
                     input logic [15:0] addr, input logic [127:0] wd,
                     output int lat, output logic [127:0] rdat,
                     output logic resp_after);
    mem_read    = rd;
    mem_write   = wr;
    mem_address = addr;
    mem_wdata   = wd;
    lat  = -1;
    rdat = '0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 1) begin
        mem_address = ~addr;
        mem_wdata   = ~wd;
      end
      if (mem_resp) begin
        lat  = i;
        rdat = mem_rdata;
        break;
      end
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    tick();
    resp_after = mem_resp;
    tick();
  endtask

  int           lat;
  logic [127:0] rdat;
  logic         ra, seen;
  logic [8:0]   pat;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_done = 1'b0;
    mem_address = '0; mem_wdata = '0;
    l1_reset = 1'b1; l1_read = 1'b0; l1_write = 1'b0; l1_done = 1'b1;
    l1_address = '0; l1_wdata = '0;
    tick(); tick();
    check("rst_resp", 128'(mem_resp), 128'd0);
    check("rst_rdata", mem_rdata, 128'd0);
    check("rst_err", 128'(proto_err), 128'd0);
    check("rst_rdcnt", 128'(rd_count), 128'd0);
    check("rst_wrcnt", 128'(wr_count), 128'd0);
    reset = 1'b0;
    l1_reset = 1'b0;

    txn(1'b0, 1'b1, 16'h0040, DA, lat, rdat, ra);
    check("wr_lat", 128'(lat), 128'd4);
    check("wr_pulse", 128'(ra), 128'd0);
    check("wr_cnt1", 128'(wr_count), 128'd1);
    check("wr_rdata", mem_rdata, 128'd0);

    txn(1'b1, 1'b0, 16'h004A, '0, lat, rdat, ra);
    check("rd_lat", 128'(lat), 128'd4);
    check("rd_data", rdat, DA);
    check("rd_cnt1", 128'(rd_count), 128'd1);
    check("rd_err", 128'(proto_err), 128'd0);

    txn(1'b0, 1'b1, 16'h0030, DB, lat, rdat, ra);
    check("wr2_cnt", 128'(wr_count), 128'd2);

    mem_read = 1'b1; mem_address = 16'h0020;
    tick(); tick();
    mem_read = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen |= mem_resp;
    end
    check("abort_resp", 128'(seen), 128'd0);
    check("abort_cnt", 128'(rd_count), 128'd1);

    txn(1'b1, 1'b0, 16'h0040, '0, lat, rdat, ra);
    check("idle_lat", 128'(lat), 128'd4);
    check("idle_data", rdat, DA);
    check("rd_cnt2", 128'(rd_count), 128'd2);

    txn(1'b1, 1'b1, 16'h0010, ONES, lat, rdat, ra);
    check("both_lat", 128'(lat), 128'd4);
    check("both_err", 128'(proto_err), 128'd1);
    check("both_wrcnt", 128'(wr_count), 128'd3);
    check("both_rdcnt", 128'(rd_count), 128'd2);
    txn(1'b1, 1'b0, 16'h0010, '0, lat, rdat, ra);
    check("both_data", rdat, ONES);
    check("err_sticky", 128'(proto_err), 128'd1);

    mem_write = 1'b1; mem_address = 16'h0030; mem_wdata = DC;
    tick(); tick();
    reset = 1'b1; mem_write = 1'b0;
    tick();
    check("rstw_resp", 128'(mem_resp), 128'd0);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen |= mem_resp;
    end
    check("rstw_noresp", 128'(seen), 128'd0);
    check("rstw_wrcnt", 128'(wr_count), 128'd0);
    check("rstw_rdcnt", 128'(rd_count), 128'd0);
    check("rstw_err", 128'(proto_err), 128'd0);
    txn(1'b1, 1'b0, 16'h0030, '0, lat, rdat, ra);
    check("rstw_data", rdat, DB);
    check("rstw_rd1", 128'(rd_count), 128'd1);

    mem_read = 1'b1; mem_address = 16'h0020;
    tick(); tick();
    mem_read = 1'b0; mem_write = 1'b1;
    tick();
    mem_write = 1'b0;
    check("swap_err", 128'(proto_err), 128'd1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen |= mem_resp;
    end
    check("swap_noresp", 128'(seen), 128'd0);
    check("swap_rdcnt", 128'(rd_count), 128'd1);
    check("swap_wrcnt", 128'(wr_count), 128'd0);

    mem_write = 1'b1; mem_address = 16'h0040; mem_wdata = DC;
    for (int i = 0; i < 4; i++) tick();
    check("rstr_resp1", 128'(mem_resp), 128'd1);
    reset = 1'b1; mem_write = 1'b0;
    tick();
    check("rstr_resp0", 128'(mem_resp), 128'd0);
    reset = 1'b0;
    tick();
    check("rstr_wrcnt", 128'(wr_count), 128'd0);
    txn(1'b1, 1'b0, 16'h0040, '0, lat, rdat, ra);
    check("rstr_data", rdat, DA);

    l1_read = 1'b1; l1_address = 16'h0050;
    pat = '0;
    for (int i = 0; i < 9; i++) begin
      tick();
      pat[i] = l1_resp;
      if (i == 1)
        check("l1_cnt_first", 128'(l1_rd_count), 128'd1);
    end
    l1_read = 1'b0;
    check("l1_pattern", 128'(pat), 128'h49);
    check("l1_rdcnt", 128'(l1_rd_count), 128'd3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/line_mem_responder.md
LINE_MEM_RESPONDER -- requirements
Module: line_mem_responder

Interface
REQ-001 Parameter: LATENCY, 4, cycles from request acceptance to mem_resp; legal range 1..15.
REQ-002 Parameter: IDX_BITS, 4, line-index width; array holds 2**IDX_BITS lines of 128 bits.
REQ-003 Port: clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: mem_read  input  1  line-read request from cache controller.
REQ-006 Port: mem_write  input  1  line-writeback request from cache controller.
REQ-007 Port: mem_done  input  1  controller end-of-writeback indication; informational only.
REQ-008 Port: mem_address  input  16  byte address; line index = mem_address[IDX_BITS+3:4]; bits [3:0] ignored.
REQ-009 Port: mem_wdata  input  128  writeback line data.
REQ-010 Port: mem_resp  output  1  one-cycle completion pulse.
REQ-011 Port: mem_rdata  output  128  read line data.
REQ-012 Port: proto_err  output  1  sticky protocol-violation flag.
REQ-013 Port: rd_count, wr_count  output  16 each  completed-transaction counters.

Function
REQ-014 FSM states SHALL be IDLE, WAIT, RESP, GAP.
REQ-015 In IDLE, mem_read or mem_write high at a posedge: latch op, line index and mem_wdata; load countdown with LATENCY-1; go WAIT, or go RESP directly when LATENCY=1.
REQ-016 In WAIT: decrement countdown each cycle; at zero go RESP. mem_address and mem_wdata changes SHALL be ignored after latching.
REQ-017 In WAIT: if the latched op's request input is low at a posedge, abort to IDLE with no response, no array write and no counter change.
REQ-018 Timing: request first sampled at edge k gives mem_resp high exactly during the cycle after edge k+LATENCY-1, for one cycle.
REQ-019 In RESP, mem_resp=1. Read: mem_rdata SHALL already show array[index] in this cycle and hold until the next read RESP. Write: array[index] <= latched wdata at the RESP-ending edge; mem_rdata unchanged.
REQ-020 At the RESP-ending edge, increment rd_count or wr_count; both SHALL saturate at 16'hFFFF.
REQ-021 RESP SHALL always go to GAP; GAP ignores all requests for one cycle, then goes IDLE. A request still high in IDLE starts a new transaction.
REQ-022 mem_read and mem_write both high when sampled in IDLE: treat as write; set proto_err.
REQ-023 Latched op's request dropping while the other request rises in WAIT: abort per REQ-017; set proto_err.
REQ-024 mem_done high outside GAP or the cycle after GAP: no effect on the FSM.
REQ-025 Read after write to the same index SHALL return the written data (no forwarding hazard, because GAP separates the two).

Reset
REQ-026 On reset: state=IDLE, mem_resp=0, mem_rdata=0, proto_err=0, rd_count=0, wr_count=0, countdown=0.
REQ-027 Array contents SHALL NOT be cleared by reset.
REQ-028 Reset mid-transaction (WAIT or RESP) SHALL cancel it: no array write, no counter increment, mem_resp low the following cycle.
REQ-029 Reset has priority over all other inputs in the same cycle.

Verification
REQ-030 LATENCY=4: write 0x0123...CDEF to 0x0040, hold until resp -> mem_resp exactly 4 cycles after first sample; wr_count=1.
REQ-031 Read 0x004A after REQ-030 -> mem_rdata=0x0123...CDEF in the resp cycle; rd_count=1; proto_err=0.
REQ-032 Read 0x0020; drop mem_read after 2 cycles -> no mem_resp; rd_count unchanged; FSM back in IDLE.
REQ-033 mem_read and mem_write high together at 0x0010 with wdata=all-ones -> write performed; proto_err=1, stays 1 until reset.
REQ-034 Reset asserted during WAIT of a write to 0x0030 -> no resp; a later read of 0x0030 returns the pre-write value; counters=0.
REQ-035 LATENCY=1: mem_read held continuously -> resp every 3rd cycle (RESP, GAP, IDLE-accept pattern); rd_count increments each response.
